uart_rx_intr: RTL and testbench

//  Serial receiver for the mother_board uart_rx pin: deserialises 8N1 frames, LSB first.

---
 rtl/uart_rx_intr_if.sv | 19 +
 rtl/uart_rx_intr.sv | 105 ++++++++++
 tb/tb_uart_rx_intr.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_intr_if.sv
// Receive-side bundle between the serial line / CPU interrupt logic and the UART receiver.
interface uart_rx_intr_if;
   logic       uart_rx;
   logic       ack;
   logic       intr;
   logic [7:0] rx_data;
   logic       overrun;
   logic       frame_err;

   modport master (
      output uart_rx, ack,
      input  intr, rx_data, overrun, frame_err
   );

   modport slave (
      input  uart_rx, ack,
      output intr, rx_data, overrun, frame_err
   );
endinterface

// File: rtl/uart_rx_intr.sv
// 8N1 UART receiver, LSB first, holding the last byte behind an interrupt/ack handshake.
// state | meaning
// IDLE  | line idle, waiting for rxs to fall
// START | half-bit delay, then confirm start bit is still low
// DATA  | sampling 8 data bits, one every WAIT cycles
// STOP  | one bit time, then sample stop bit and post the byte
module uart_rx_intr #(
   parameter int WAIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_intr_if.slave bus
);
   localparam int HALF = WAIT / 2;
   localparam int CW   = $clog2(WAIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync_q;
   logic          rxs;
   logic [CW-1:0] tmr, tmr_load;
   logic [2:0]    bitcnt;
   logic [7:0]    shift;
   logic          tmr_done;
   logic          stop_done;

   assign rxs      = sync_q[1];
   assign tmr_done = (tmr == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], bus.uart_rx};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stop_done = 1'b0;
      tmr_load  = '0;
      unique case (state)
         IDLE:  if (!rxs) state_nxt = START;
         START: if (tmr_done) state_nxt = rxs ? IDLE : DATA;
         DATA:  if (tmr_done && bitcnt == 3'd7) state_nxt = STOP;
         STOP:  if (tmr_done) begin
                   state_nxt = IDLE;
                   stop_done = 1'b1;
                end
         default: state_nxt = IDLE;
      endcase
      unique case (state_nxt)
         START:       tmr_load = CW'(HALF - 1);
         DATA, STOP:  tmr_load = CW'(WAIT - 1);
         default:     tmr_load = '0;
      endcase
   end

   // Timer reloads on every state change and after each data-bit sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr    <= '0;
         bitcnt <= 3'd0;
         shift  <= 8'h00;
      end else begin
         if (state_nxt != state)          tmr <= tmr_load;
         else if (!tmr_done)              tmr <= tmr - CW'(1);
         else if (state == DATA)          tmr <= CW'(WAIT - 1);

         if (state == START)              bitcnt <= 3'd0;
         else if (state == DATA && tmr_done) begin
            shift[bitcnt] <= rxs;
            bitcnt        <= bitcnt + 3'd1;
         end
      end
   end

   // A new byte landing in the same cycle as ack replaces the old one rather than overrunning.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.intr      <= 1'b0;
         bus.rx_data   <= 8'h00;
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
      end else if (stop_done && rxs) begin
         bus.frame_err <= 1'b0;
         if (!bus.intr || bus.ack) begin
            bus.rx_data <= shift;
            bus.intr    <= 1'b1;
            bus.overrun <= 1'b0;
         end else begin
            bus.overrun <= 1'b1;
         end
      end else begin
         if (stop_done) bus.frame_err <= 1'b1;
         if (bus.intr && bus.ack) begin
            bus.intr    <= 1'b0;
            bus.overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_intr.sv
// Directed bench for uart_rx_intr: 8N1 frames, glitches, overrun, framing error, mid-frame reset.
module tb_uart_rx_intr;
   localparam int WAIT = 8;

   logic clk;
   logic reset;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   lat;

   uart_rx_intr_if bus ();

   uart_rx_intr #(.WAIT(WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      @(posedge clk);
      #1 bus.uart_rx = 1'b0;
      repeat (WAIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 bus.uart_rx = d[i];
         repeat (WAIT) @(posedge clk);
      end
      #1 bus.uart_rx = stop_bit;
      repeat (WAIT) @(posedge clk);
      #1 bus.uart_rx = 1'b1;
   endtask

   task automatic pulse_ack();
      @(posedge clk);
      #1 bus.ack = 1'b1;
      @(posedge clk);
      #1 bus.ack = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bus.uart_rx = 1'b1;
      bus.ack     = 1'b0;
      reset       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_intr",      32'(bus.intr),      32'h0);
      chk("rst_rx_data",   32'(bus.rx_data),   32'h00);
      chk("rst_overrun",   32'(bus.overrun),   32'h0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
      reset = 1'b1;
      repeat (4) @(posedge clk);

      // 1: 0xA5, intr must rise within 79 cycles of the start edge
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk);
            do begin
               @(posedge clk);
               lat++;
               #2;
            end while (!bus.intr && lat < 100);
         end
      join
      chk("t1_latency_le79", 32'(lat <= 79 && lat >= 70), 32'h1);
      settle();
      chk("t1_intr",      32'(bus.intr),      32'h1);
      chk("t1_rx_data",   32'(bus.rx_data),   32'hA5);
      chk("t1_overrun",   32'(bus.overrun),   32'h0);
      chk("t1_frame_err", 32'(bus.frame_err), 32'h0);

      // 2: ack clears intr, data held
      pulse_ack();
      chk("t2_intr",    32'(bus.intr),    32'h0);
      chk("t2_rx_data", 32'(bus.rx_data), 32'hA5);

      // 3: 2-cycle glitch is rejected
      @(posedge clk);
      #1 bus.uart_rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.uart_rx = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t3_intr",    32'(bus.intr),    32'h0);
      chk("t3_rx_data", 32'(bus.rx_data), 32'hA5);

      // 4: back-to-back frames without ack -> overrun
      send_frame(8'h3C, 1'b1);
      send_frame(8'h81, 1'b1);
      settle();
      chk("t4_rx_data", 32'(bus.rx_data), 32'h3C);
      chk("t4_intr",    32'(bus.intr),    32'h1);
      chk("t4_overrun", 32'(bus.overrun), 32'h1);
      pulse_ack();
      chk("t4_ack_intr",    32'(bus.intr),    32'h0);
      chk("t4_ack_overrun", 32'(bus.overrun), 32'h0);

      // 5: bad stop bit, then a good frame clears frame_err
      send_frame(8'h55, 1'b0);
      settle();
      chk("t5_frame_err", 32'(bus.frame_err), 32'h1);
      chk("t5_intr",      32'(bus.intr),      32'h0);
      chk("t5_rx_data",   32'(bus.rx_data),   32'h3C);
      send_frame(8'h12, 1'b1);
      settle();
      chk("t5_good_frame_err", 32'(bus.frame_err), 32'h0);
      chk("t5_good_rx_data",   32'(bus.rx_data),   32'h12);
      chk("t5_good_intr",      32'(bus.intr),      32'h1);

      // ack coincident with the accept edge: new byte wins, no overrun
      fork
         send_frame(8'h6B, 1'b1);
         begin
            @(posedge clk);
            repeat (78) @(posedge clk);
            #1 bus.ack = 1'b1;
            @(posedge clk);
            #1 bus.ack = 1'b0;
         end
      join
      settle();
      chk("ackacc_intr",    32'(bus.intr),    32'h1);
      chk("ackacc_rx_data", 32'(bus.rx_data), 32'h6B);
      chk("ackacc_overrun", 32'(bus.overrun), 32'h0);
      pulse_ack();
      chk("ackacc_clr_intr", 32'(bus.intr), 32'h0);

      // 6: reset during data bit 4 of 0xFF, then 0x0F
      fork
         send_frame(8'hFF, 1'b1);
         begin
            @(posedge clk);
            repeat (WAIT * 5 + 4) @(posedge clk);
            #1 reset = 1'b0;
            #1;
            chk("t6_rst_intr",    32'(bus.intr),    32'h0);
            chk("t6_rst_rx_data", 32'(bus.rx_data), 32'h00);
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t6_no_spurious_intr", 32'(bus.intr), 32'h0);
      send_frame(8'h0F, 1'b1);
      settle();
      chk("t6_rx_data",   32'(bus.rx_data),   32'h0F);
      chk("t6_intr",      32'(bus.intr),      32'h1);
      chk("t6_overrun",   32'(bus.overrun),   32'h0);
      chk("t6_frame_err", 32'(bus.frame_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
